// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF input synchroniser, mid-bit sampling FSM,
// one-cycle data_valid / frame_err strobes and break suppression.
module uart_rx_byte #(
    parameter int Fclk    = 50 * 1000000,
    parameter int Fuart   = 9600,
    parameter int divider = Fclk / Fuart
) (
    input  logic       clk_Rx,
    input  logic       reset,
    input  logic       Rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START_CHECK = 3'd1,
        DATA_BIT    = 3'd2,
        STOP_BIT    = 3'd3,
        BREAK_WAIT  = 3'd4
    } state_t;

    localparam logic [24:0] CNT_LAST = 25'(divider - 1);
    localparam logic [24:0] CNT_MID  = 25'(divider / 2 - 1);

    state_t      state;
    logic [24:0] cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        rx_meta;
    logic        rx_s;

    // Both stages reset high so a reset never looks like a falling start edge.
    always_ff @(posedge clk_Rx or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_Rx or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here make the strobes one-cycle pulses; later
            // assignments in the same pass override them without a read-after-write hazard.
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (!rx_s) begin
                        state   <= START_CHECK;
                        rx_busy <= 1'b1;
                    end
                end
                START_CHECK: begin
                    if (cnt == CNT_MID) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state <= DATA_BIT;
                        end
                    end else begin
                        cnt <= cnt + 25'd1;
                    end
                end
                DATA_BIT: begin
                    if (cnt == CNT_LAST) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP_BIT;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 25'd1;
                    end
                end
                STOP_BIT: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                            rx_busy    <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 25'd1;
                    end
                end
                BREAK_WAIT: begin
                    // A held-low line must not be re-read as a run of 0x00 bytes.
                    if (rx_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    bit_cnt <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: divider 16 for the functional cases,
// divider 100 driven by a 101-clock sender for the tolerance case.
module tb_uart_rx_byte;

    logic       clk_Rx;
    logic       reset;
    logic       rx16;
    logic       rx100;
    logic [7:0] dout16, dout100;
    logic       dv16, dv100, fe16, fe100, busy16, busy100;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    uart_rx_byte #(.divider(16)) dut16 (
        .clk_Rx(clk_Rx), .reset(reset), .Rx_in(rx16),
        .data_out(dout16), .data_valid(dv16), .frame_err(fe16), .rx_busy(busy16)
    );

    uart_rx_byte #(.divider(100)) dut100 (
        .clk_Rx(clk_Rx), .reset(reset), .Rx_in(rx100),
        .data_out(dout100), .data_valid(dv100), .frame_err(fe100), .rx_busy(busy100)
    );

    initial clk_Rx = 1'b0;
    always #5 clk_Rx = ~clk_Rx;

    always @(posedge clk_Rx) cyc <= cyc + 1;

    // Pulse log, sampled on the falling edge.
    logic [7:0] q16[$];
    int         qt16[$];
    logic [7:0] q100[$];
    int         fe_cnt16  = 0;
    int         fe_cnt100 = 0;
    int         viol      = 0;
    logic       prev_dv16 = 1'b0, prev_fe16 = 1'b0, prev_dv100 = 1'b0, prev_fe100 = 1'b0;

    always @(negedge clk_Rx) begin
        if (dv16) begin
            q16.push_back(dout16);
            qt16.push_back(cyc);
        end
        if (dv100) q100.push_back(dout100);
        if (fe16) fe_cnt16 = fe_cnt16 + 1;
        if (fe100) fe_cnt100 = fe_cnt100 + 1;
        if ((dv16 && fe16) || (dv100 && fe100)) viol = viol + 1;
        if ((dv16 && prev_dv16) || (fe16 && prev_fe16)) viol = viol + 1;
        if ((dv100 && prev_dv100) || (fe100 && prev_fe100)) viol = viol + 1;
        prev_dv16  = dv16;
        prev_fe16  = fe16;
        prev_dv100 = dv100;
        prev_fe100 = fe100;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared = compared + 1;
        if (got !== exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx100 = v;
        else     rx16  = v;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_Rx);
    endtask

    // Called at a falling edge; leaves the line at the stop-bit level.
    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop_v,
                              input int per, output int start_cyc);
        start_cyc = cyc;
        drive(sel, 1'b0);
        wait_clks(per);
        for (int i = 0; i < 8; i++) begin
            drive(sel, b[i]);
            wait_clks(per);
        end
        drive(sel, stop_v);
        wait_clks(per);
    endtask

    int base, fbase, st0, st1, lat, gap;

    initial begin
        reset = 1'b0;
        rx16  = 1'b1;
        rx100 = 1'b1;
        wait_clks(3);
        check("reset_data_out", 32'(dout16), 32'h00);
        check("reset_valid", 32'(dv16), 32'd0);
        check("reset_frame_err", 32'(fe16), 32'd0);
        check("reset_busy", 32'(busy16 | busy100), 32'd0);
        reset = 1'b1;
        wait_clks(5);

        // 1: nominal byte with latency window H + 9*div + 3 (+/-1) = 155 +/- 1
        base = q16.size();
        fbase = fe_cnt16;
        send_frame(1'b0, 8'hA5, 1'b1, 16, st0);
        wait_clks(32);
        check("t1_valid_count", 32'(q16.size() - base), 32'd1);
        if (q16.size() > base) begin
            check("t1_data", 32'(q16[base]), 32'hA5);
            lat = qt16[base] - (st0 + 1);
            check("t1_latency_in_154_156", 32'(lat >= 154 && lat <= 156), 32'd1);
        end
        check("t1_data_out", 32'(dout16), 32'hA5);
        check("t1_frame_err", 32'(fe_cnt16 - fbase), 32'd0);
        check("t1_busy_idle", 32'(busy16), 32'd0);

        // 2: back-to-back 0x00, 0xFF, pulses 160 +/- 1 apart
        base = q16.size();
        send_frame(1'b0, 8'h00, 1'b1, 16, st0);
        send_frame(1'b0, 8'hFF, 1'b1, 16, st1);
        wait_clks(32);
        check("t2_valid_count", 32'(q16.size() - base), 32'd2);
        if (q16.size() >= base + 2) begin
            check("t2_first", 32'(q16[base]), 32'h00);
            check("t2_second", 32'(q16[base+1]), 32'hFF);
            gap = qt16[base+1] - qt16[base];
            check("t2_gap_in_159_161", 32'(gap >= 159 && gap <= 161), 32'd1);
        end

        // 3: 4-clock start glitch, then a real 0x3C
        base = q16.size();
        fbase = fe_cnt16;
        rx16 = 1'b0;
        wait_clks(4);
        check("t3_busy_during_glitch", 32'(busy16), 32'd1);
        rx16 = 1'b1;
        wait_clks(12);
        check("t3_busy_cleared", 32'(busy16), 32'd0);
        check("t3_no_valid", 32'(q16.size() - base), 32'd0);
        check("t3_no_frame_err", 32'(fe_cnt16 - fbase), 32'd0);
        send_frame(1'b0, 8'h3C, 1'b1, 16, st0);
        wait_clks(20);
        check("t3_data_out", 32'(dout16), 32'h3C);

        // 4: framing error + break; 0x42 first so the held value differs from the bad byte
        send_frame(1'b0, 8'h42, 1'b1, 16, st0);
        wait_clks(20);
        base = q16.size();
        fbase = fe_cnt16;
        send_frame(1'b0, 8'h3C, 1'b0, 16, st0);
        wait_clks(30);
        check("t4_break_wait_busy", 32'(busy16), 32'd1);
        check("t4_frame_err_count", 32'(fe_cnt16 - fbase), 32'd1);
        check("t4_no_valid", 32'(q16.size() - base), 32'd0);
        check("t4_data_out_held", 32'(dout16), 32'h42);
        rx16 = 1'b1;
        wait_clks(8);
        check("t4_idle_after_break", 32'(busy16), 32'd0);
        send_frame(1'b0, 8'h81, 1'b1, 16, st0);
        wait_clks(20);
        check("t4_next_byte", 32'(dout16), 32'h81);
        check("t4_valid_total", 32'(q16.size() - base), 32'd1);

        // 5: asynchronous reset during data bit 4
        base = q16.size();
        fbase = fe_cnt16;
        rx16 = 1'b0;
        wait_clks(16);
        for (int i = 0; i < 4; i++) begin
            rx16 = 1'(i & 1);
            wait_clks(16);
        end
        rx16 = 1'b1;
        wait_clks(8);
        #1 reset = 1'b0;
        #1;
        check("t5_async_data_out", 32'(dout16), 32'h00);
        check("t5_async_busy", 32'(busy16), 32'd0);
        wait_clks(3);
        reset = 1'b1;
        wait_clks(60);
        check("t5_no_pulses", 32'(q16.size() - base + fe_cnt16 - fbase), 32'd0);
        send_frame(1'b0, 8'h5A, 1'b1, 16, st0);
        wait_clks(20);
        check("t5_next_byte", 32'(dout16), 32'h5A);

        // 6: sender at 101 clocks per bit into divider 100
        base = q100.size();
        fbase = fe_cnt100;
        send_frame(1'b1, 8'h96, 1'b1, 101, st0);
        send_frame(1'b1, 8'h69, 1'b1, 101, st0);
        send_frame(1'b1, 8'hF0, 1'b1, 101, st0);
        wait_clks(150);
        check("t6_valid_count", 32'(q100.size() - base), 32'd3);
        if (q100.size() >= base + 3) begin
            check("t6_byte0", 32'(q100[base]), 32'h96);
            check("t6_byte1", 32'(q100[base+1]), 32'h69);
            check("t6_byte2", 32'(q100[base+2]), 32'hF0);
        end
        check("t6_frame_err", 32'(fe_cnt100 - fbase), 32'd0);

        check("pulse_rules", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

UART receiver that deserialises an 8N1 byte stream (1 start, 8 data LSB-first, 1 stop) from a single asynchronous line into a parallel byte with a one-cycle valid strobe. It is the downstream counterpart of the project's UART transmitter: it consumes that transmitter's serial output, or an external link at the same baud rate. It presents received bytes to the control logic, and flags framing errors and start-bit glitches without producing data.

## Interface
- `Fclk`, default 50 * 1000000: system clock frequency in Hz.
- `Fuart`, default 9600: baud rate in bit/s.
- `divider`, default Fclk / Fuart: clocks per bit period. The value must be ≥ 8.
- `clk_Rx`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Rx_in`  in  1  serial line. It idles high and is asynchronous to `clk_Rx`.
- `data_out`  out  8  last correctly framed byte. It holds its value until the next good byte.
- `data_valid`  out  1  one-cycle pulse when `data_out` has just been updated.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `rx_busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Input synchroniser**
  - `Rx_in` passes through a 2-FF synchroniser; the output is `rx_s`.
  - Both flops reset to 1, so reset never produces a false start.
  - All FSM decisions use `rx_s` only.
- **Bit counter and sample points**
  - Bit-timing counter `cnt` is 25 bits wide and `bit_cnt` is 3 bits wide.
  - `H = divider / 2` (integer division).
- **FSM states**: IDLE, START_CHECK, DATA_BIT, STOP_BIT, BREAK_WAIT.
  - **IDLE**: `cnt` = 0, `bit_cnt` = 0. If `rx_s` == 0, go to START_CHECK.
  - **START_CHECK**: `cnt` increments.
    - At `cnt` == H-1 (mid start bit), `rx_s` is sampled.
    - If `rx_s` == 1: the event is a glitch. Go to IDLE; no output pulse.
    - If `rx_s` == 0: clear `cnt`, clear `bit_cnt`, go to DATA_BIT.
  - **DATA_BIT**: `cnt` increments.
    - At `cnt` == divider-1, shift the sample into the register: `shreg <= {rx_s, shreg[7:1]}` (LSB first). Then clear `cnt`.
    - If `bit_cnt` == 7, go to STOP_BIT; otherwise `bit_cnt` increments.
  - **STOP_BIT**: at `cnt` == divider-1, `rx_s` is sampled.
    - If `rx_s` == 1: `data_out <= shreg`, pulse `data_valid`, go to IDLE.
    - If `rx_s` == 0: pulse `frame_err`, leave `data_out` unchanged, go to BREAK_WAIT.
  - **BREAK_WAIT**: stay until `rx_s` == 1, then go to IDLE. This stops a held-low line (break) from being re-read as a stream of 0x00 bytes.
  - **Any undefined state encoding** goes to IDLE on the next clock.
- **Output rules**
  - `data_valid` and `frame_err` are never high in the same cycle.
  - Neither pulse is ever longer than one cycle.

## Timing
- **Reset values**
  - `data_out` = 8'h00, `data_valid` = 0, `frame_err` = 0, `rx_busy` = 0.
  - FSM in IDLE, `cnt` = 0, `bit_cnt` = 0, `shreg` = 0, synchroniser flops = 1.
- **Reset behaviour**
  - Reset acts immediately (asynchronous) and releases synchronously on the next `clk_Rx` edge.
  - Reset mid-frame abandons the frame and produces no pulse.
  - After release, the block waits in IDLE for a fresh falling edge. If the line is still low at release, the block enters START_CHECK and the glitch/framing logic handles it.
- **Latency**
  - Synchroniser latency is 2 clocks. IDLE→START_CHECK takes 1 clock.
  - `data_valid` rises H + 9·divider + 3 clocks (±1) after the first clock edge that samples `Rx_in` low.
- **Back-to-back frames**
  - After `data_valid`, the FSM is in IDLE in the same cycle that the pulse is visible.
  - A start bit following the stop bit with zero idle time is received.
- **Sampling and tolerance**
  - Data bits are sampled at mid-bit (offset H from the detected edge).
  - Tolerated sender bit period: divider·(1 ± 0.45/9.5) clocks, including a sender using divider+1 clocks per bit.
- **`rx_busy`**: rises 1 clock after `rx_s` falls in IDLE, and falls in the cycle the FSM re-enters IDLE.

## Test plan
Tests 1–5 use divider = 16; test 6 uses divider = 100.
1. **Nominal byte**: send 0xA5 with a 16-clock bit period → exactly one `data_valid` pulse, `data_out` = 0xA5, `frame_err` never high, `rx_busy` back to 0.
2. **Back-to-back bytes**: send 0x00 then 0xFF with no idle gap after the stop bit → two `data_valid` pulses 160 clocks (±1) apart, values 0x00 then 0xFF.
3. **Start glitch**: drive `Rx_in` low for 4 clocks, then high → no `data_valid`/`frame_err`; `rx_busy` high then back to 0 within H+4 clocks. A following 0x3C is received correctly.
4. **Framing error and break**: send 0x3C with the stop bit low and the line held low for 3 bit periods → one `frame_err` pulse, no `data_valid`, `data_out` keeps its prior value, FSM stays in BREAK_WAIT while the line is low. After the line returns high, a following 0x81 is received correctly.
5. **Reset mid-frame**: assert `reset` during data bit 4 of a byte → all outputs reset in the same cycle (asynchronous), no pulses. After release, with the line high, a following 0x5A is received correctly.
6. **Slow sender**: sender period of 101 clocks per bit, sending 0x96, 0x69, 0xF0 back-to-back → three correct `data_valid` pulses, zero `frame_err`.
